// File: rtl/core_wb_pkg.sv
// Shared writeback types and widths for the register-file write-port arbiter.
// Optional forwarding outputs of regfile_wb_arbiter are enabled by WB_FORWARD_EN.
package core_wb_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr upward, wrapping N-1 -> 0.
// Emits a one-hot grant, the encoded winner index and an any-grant flag.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves a latch.
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      cand = sum[IW-1:0];
      if (!valid && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register file's single write port among NUM_SRC requesters.
// Define WB_FORWARD_EN to drive fwd_hit1/fwd_hit2/fwd_data; otherwise they are tied to 0.
module regfile_wb_arbiter #(
  parameter  int NUM_SRC = 3,
  parameter  int XLEN    = core_wb_pkg::XLEN,
  parameter  int AW      = core_wb_pkg::AW,
  localparam int PW      = $clog2(NUM_SRC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [NUM_SRC*AW-1:0]   src_addr,
  input  logic [NUM_SRC*XLEN-1:0] src_data,
  output logic [NUM_SRC-1:0]      src_ready,
  output logic                    writeEn,
  output logic [AW-1:0]           writeAddr,
  output logic [XLEN-1:0]         writeData,
  input  logic [AW-1:0]           rd_addr1,
  input  logic [AW-1:0]           rd_addr2,
  output logic                    fwd_hit1,
  output logic                    fwd_hit2,
  output logic [XLEN-1:0]         fwd_data
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(core_wb_pkg::REG_ZERO);

  logic [PW-1:0]      rr_ptr;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] grant;
  logic [PW-1:0]      gidx;
  logic               gany;
  logic [AW-1:0]      sel_addr;
  logic [XLEN-1:0]    sel_data;

  // Requests are masked during reset so nothing is handshaken that the reset would drop.
  assign req       = src_valid & {NUM_SRC{~rst}};
  assign src_ready = grant;

  rr_arbiter #(.N(NUM_SRC)) u_rr (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx),
    .valid (gany)
  );

  always_comb begin
    sel_addr = src_addr[gidx*AW +: AW];
    sel_data = src_data[gidx*XLEN +: XLEN];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      rr_ptr    <= '0;
      writeEn   <= 1'b0;
      writeAddr <= '0;
      writeData <= '0;
    end else if (gany) begin
      rr_ptr    <= (gidx == PW'(NUM_SRC-1)) ? '0 : gidx + 1'b1;
      // x0 writes are consumed like any other but never reach the register file.
      writeEn   <= (sel_addr != ZERO_ADDR);
      writeAddr <= sel_addr;
      writeData <= sel_data;
    end else begin
      writeEn   <= 1'b0;
    end
  end

`ifdef WB_FORWARD_EN
  // Covers the half cycle between the registered write and the negedge commit.
  assign fwd_hit1 = writeEn && (writeAddr == rd_addr1) && (rd_addr1 != ZERO_ADDR);
  assign fwd_hit2 = writeEn && (writeAddr == rd_addr2) && (rd_addr2 != ZERO_ADDR);
  assign fwd_data = writeData;
`else
  logic unused_rd;
  assign unused_rd = ^{rd_addr1, rd_addr2};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data  = '0;
`endif

endmodule
